cpu_prog_loader: RTL and testbench
==================================

CPU_PROG_LOADER -- requirements
Module: cpu_prog_loader

Interface
REQ-001 The block SHALL provide parameter CSUM_EN, default 1, which enables checksum-byte checking after the 16 program bytes.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  the single clock; all state is updated on the posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 address  input  4  CPU program counter (the instruction fetch address).
REQ-006 instruction  output  8  instruction word returned to the CPU; {opecode[7:4], immediate[3:0]}.
REQ-007 ld_start  input  1  single-cycle pulse that begins a program load.
REQ-008 ld_valid  input  1  the load byte on ld_data is valid.
REQ-009 ld_data  input  8  load byte.
REQ-010 ld_ready  output  1  the loader accepts ld_data in this cycle.
REQ-011 cpu_rstn  output  1  active-low reset driven to the CPU.
REQ-012 busy  output  1  a load is in progress.
REQ-013 err  output  1  the last load failed its checksum; sticky until the next ld_start or rst.

Function
REQ-014 The memory SHALL be 16 x 8; instruction SHALL equal mem[address] combinationally, with zero-cycle latency, in every state.
REQ-015 The state machine SHALL have states IDLE, LOAD, CSUM, RUN and ERR; rst SHALL force IDLE.
REQ-016 A byte SHALL be accepted exactly on a posedge where ld_valid and ld_ready are both 1.
REQ-017 ld_ready SHALL be 1 only in LOAD and in CSUM.
REQ-018 IDLE, RUN or ERR, with ld_start=1 -> LOAD: wr_ptr=0, sum=0, err=0.
REQ-019 Each accepted byte in LOAD SHALL write mem[wr_ptr]=ld_data, set wr_ptr=wr_ptr+1 (4-bit), and set sum=sum+ld_data modulo 256.
REQ-020 When the accepted byte is at wr_ptr=15, the next state SHALL be CSUM if CSUM_EN=1, otherwise RUN.
REQ-021 In CSUM, an accepted byte equal to (sum of the 16 bytes) mod 256 -> RUN; any other value -> ERR with err=1.
REQ-022 ld_start in LOAD or CSUM SHALL restart the load: wr_ptr=0, sum=0, state LOAD. A byte offered in the same cycle SHALL be discarded.
REQ-023 ld_valid outside LOAD/CSUM SHALL be ignored, with no memory write.
REQ-024 cpu_rstn SHALL be 1 only in RUN, decoded directly from the state register, so the CPU leaves reset on the cycle after the last accepted byte.
REQ-025 busy SHALL be 1 in LOAD and CSUM.
REQ-026 Memory writes already made in LOAD SHALL be kept on ERR or restart; the CPU stays in reset until a load completes successfully.
REQ-027 ld_valid deasserted mid-load SHALL stall the load indefinitely, with no timeout.

Reset
REQ-028 rst SHALL set state=IDLE, every mem entry=8'h00, wr_ptr=0, sum=0, err=0.
REQ-029 While in reset, the outputs SHALL be cpu_rstn=0, ld_ready=0, busy=0, instruction=8'h00.
REQ-030 rst asserted mid-load SHALL abort the load immediately, with no partial commit beyond the bytes already written.

Structure
REQ-031 The state encoding, DEPTH=16, ADDR_W=4 and DATA_W=8 SHALL live in a shared package cpu_pkg.
REQ-032 The storage SHALL be one sub-module, cpu_prog_ram: 16x8 array, synchronous write, asynchronous read, async clear on rst.
REQ-033 The top level SHALL contain the state machine, wr_ptr, the checksum accumulator and the output decode.

Verification
REQ-034 Good load: ld_start, then bytes 0x31,0x42,...,0x00 (16 bytes), then the correct sum -> cpu_rstn rises 1 cycle after the sum byte; instruction at address=0 reads 0x31 and at address=1 reads 0x42.
REQ-035 Bad checksum: the same 16 bytes, then sum+1 -> err=1, cpu_rstn stays 0, ld_ready=0; a subsequent ld_start clears err.
REQ-036 Backpressure gaps: ld_valid toggled 1/0 every cycle -> exactly 16+1 bytes are accepted; mem contents match the stimulus; busy stays 1 throughout.
REQ-037 Restart: ld_start after 7 bytes, then a full good load of 0xA0..0xAF -> mem[0]=0xA0 and mem[15]=0xAF; RUN is reached.
REQ-038 CSUM_EN=0: 16 bytes of 0xB3 -> RUN immediately after byte 16; a 17th ld_valid is ignored.
REQ-039 Reset mid-load: rst pulsed after 5 bytes -> all mem entries = 0x00, state IDLE, cpu_rstn=0, instruction=0x00 at every address.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared sizing and state encoding for the CPU program loader and its storage.
package cpu_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_prog_ram.sv
// 16x8 program store: synchronous write, asynchronous read, cleared by rst.
module cpu_prog_ram
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_prog_loader.sv
// Loads a 16-byte program over a valid/ready byte stream, optionally verifies a
// trailing checksum byte, and holds the CPU in reset until a load succeeds.
module cpu_prog_loader
  import cpu_pkg::*;
#(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              err,
  output logic [2:0]        fsm_state
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              mem_we;

  // Handshake: a byte transfers on a posedge where ld_valid && ld_ready.
  // ld_ready depends on state only; ld_start in the same cycle wins and the
  // offered byte is dropped.
  assign accept = ld_valid & ld_ready & ~ld_start;
  assign mem_we = accept & (state == ST_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (ld_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_start) begin
          state_nxt = ST_LOAD;
        end else if (accept && (wr_ptr == ADDR_W'(DEPTH - 1))) begin
          state_nxt = CSUM_EN ? ST_CSUM : ST_RUN;
        end
      end
      ST_CSUM: begin
        if (ld_start) begin
          state_nxt = ST_LOAD;
        end else if (accept) begin
          state_nxt = (ld_data == sum) ? ST_RUN : ST_ERR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    busy     = 1'b0;
    cpu_rstn = 1'b0;
    case (state)
      ST_LOAD, ST_CSUM: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_RUN:  cpu_rstn = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state = state;

  // Write pointer and running checksum; err stays set until the next load begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      sum    <= '0;
      err    <= 1'b0;
    end else if (ld_start) begin
      wr_ptr <= '0;
      sum    <= '0;
      err    <= 1'b0;
    end else begin
      if (mem_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        sum    <= sum + ld_data;
      end
      if (accept && (state == ST_CSUM) && (ld_data != sum)) err <= 1'b1;
    end
  end

  cpu_prog_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (ld_data),
    .raddr (address),
    .rdata (instruction)
  );

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed scoreboard bench for cpu_prog_loader (checksum on) plus a second
// instance with the checksum stage disabled.
`timescale 1ns/1ps
module tb_cpu_prog_loader;
  import cpu_pkg::*;

  localparam logic [7:0] K_INST   = 8'd0;
  localparam logic [7:0] K_RSTN   = 8'd1;
  localparam logic [7:0] K_READY  = 8'd2;
  localparam logic [7:0] K_BUSY   = 8'd3;
  localparam logic [7:0] K_ERR    = 8'd4;
  localparam logic [7:0] K_STATE  = 8'd5;
  localparam logic [7:0] K_ACC    = 8'd6;
  localparam logic [7:0] K_INST2  = 8'd7;
  localparam logic [7:0] K_RSTN2  = 8'd8;
  localparam logic [7:0] K_READY2 = 8'd9;
  localparam logic [7:0] K_STATE2 = 8'd10;
  localparam logic [7:0] K_CLRACC = 8'd11;

  typedef struct packed {
    logic [7:0] kind;
    logic [7:0] exp;
  } chk_t;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] address, address2;
  logic [7:0] instruction, instruction2;
  logic       ld_start, ld_valid, ld_start2, ld_valid2;
  logic [7:0] ld_data, ld_data2;
  logic       ld_ready, cpu_rstn, busy, err;
  logic       ld_ready2, cpu_rstn2, busy2, err2;
  logic [2:0] fsm_state, fsm_state2;

  always #5 clk = ~clk;

  cpu_prog_loader #(.CSUM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .address(address), .instruction(instruction),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_rstn(cpu_rstn), .busy(busy), .err(err),
    .fsm_state(fsm_state)
  );

  cpu_prog_loader #(.CSUM_EN(1'b0)) dut_nocsum (
    .clk(clk), .rst(rst), .address(address2), .instruction(instruction2),
    .ld_start(ld_start2), .ld_valid(ld_valid2), .ld_data(ld_data2),
    .ld_ready(ld_ready2), .cpu_rstn(cpu_rstn2), .busy(busy2), .err(err2),
    .fsm_state(fsm_state2)
  );

  // ---------------- scoreboard ----------------
  chk_t       chk_q[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  int         acc_cnt  = 0;
  int         to_cnt   = 0;
  logic       done = 1'b0;
  logic       report_done = 1'b0;
  chk_t       mon_c;
  logic [7:0] mon_act, mon_exp;
  logic [7:0] pat [16];

  function automatic string kind_name(input logic [7:0] k);
    case (k)
      K_INST:   return "instruction";
      K_RSTN:   return "cpu_rstn";
      K_READY:  return "ld_ready";
      K_BUSY:   return "busy";
      K_ERR:    return "err";
      K_STATE:  return "state";
      K_ACC:    return "accepted_bytes";
      K_INST2:  return "nocsum_instruction";
      K_RSTN2:  return "nocsum_cpu_rstn";
      K_READY2: return "nocsum_ld_ready";
      K_STATE2: return "nocsum_state";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [7:0] actual(input logic [7:0] k);
    case (k)
      K_INST:   return instruction;
      K_RSTN:   return {7'd0, cpu_rstn};
      K_READY:  return {7'd0, ld_ready};
      K_BUSY:   return {7'd0, busy};
      K_ERR:    return {7'd0, err};
      K_STATE:  return {5'd0, fsm_state};
      K_ACC:    return acc_cnt[7:0];
      K_INST2:  return instruction2;
      K_RSTN2:  return {7'd0, cpu_rstn2};
      K_READY2: return {7'd0, ld_ready2};
      K_STATE2: return {5'd0, fsm_state2};
      default:  return 8'hEE;
    endcase
  endfunction

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      if (mon_c.kind == K_CLRACC) begin
        acc_cnt = 0;
      end else begin
        n_checks++;
        mon_act = actual(mon_c.kind);
        if (mon_act !== mon_c.exp) begin
          n_fails++;
          $display("FAIL %s: got %02h, expected %02h (t=%0t)",
                   kind_name(mon_c.kind), mon_act, mon_c.exp, $time);
        end
      end
    end
    if (ld_valid && ld_ready && !ld_start) begin
      n_checks++;
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL accept_data: got %02h, expected no accept (t=%0t)", ld_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ld_data !== mon_exp) begin
          n_fails++;
          $display("FAIL accept_data: got %02h, expected %02h (t=%0t)", ld_data, mon_exp, $time);
        end
      end
    end
    if (done && !report_done) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fails++;
        $display("FAIL pending_bytes: got %0d, expected 0", exp_q.size());
      end
      n_checks++;
      if (to_cnt != 0) begin
        n_fails++;
        $display("FAIL ready_timeout: got %0d, expected 0", to_cnt);
      end
      report_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [7:0] k, input logic [7:0] v);
    chk_q.push_back({k, v});
  endtask

  task automatic expect_state(input state_t s);
    expect_v(K_STATE, {5'd0, s});
  endtask

  task automatic start_load;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic ok;
    ld_valid = 1'b1;
    ld_data  = d;
    exp_q.push_back(d);
    ok = 1'b0;
    for (int n = 0; n < 32; n++) begin
      ok = ld_ready;
      tick();
      if (ok) break;
    end
    ld_valid = 1'b0;
    if (!ok) to_cnt++;
  endtask

  task automatic send_ignored(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_pat;
    for (int i = 0; i < 16; i++) send_byte(pat[i]);
  endtask

  task automatic read_check(input logic [3:0] a, input logic [7:0] e);
    address = a;
    expect_v(K_INST, e);
    tick();
  endtask

  task automatic reset_dut;
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    tick();
    expect_v(K_RSTN, 8'h00);
    expect_v(K_READY, 8'h00);
    expect_v(K_BUSY, 8'h00);
    expect_v(K_ERR, 8'h00);
    expect_state(ST_IDLE);
    for (int i = 0; i < 16; i++) read_check(4'(i), 8'h00);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; address = '0; address2 = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_start2 = 1'b0; ld_valid2 = 1'b0; ld_data2 = '0;
    reset_dut();

    // Checksum disabled: 16 x 0xB3 reaches RUN directly; a 17th byte is ignored.
    ld_start2 = 1'b1;
    tick();
    ld_start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid2 = 1'b1;
      ld_data2  = 8'hB3;
      expect_v(K_READY2, 8'h01);
      expect_v(K_STATE2, {5'd0, ST_LOAD});
      tick();
    end
    ld_data2 = 8'h5A;
    expect_v(K_STATE2, {5'd0, ST_RUN});
    expect_v(K_RSTN2, 8'h01);
    expect_v(K_READY2, 8'h00);
    tick();
    ld_valid2 = 1'b0;
    expect_v(K_STATE2, {5'd0, ST_RUN});
    address2 = 4'd0;
    expect_v(K_INST2, 8'hB3);
    tick();
    address2 = 4'd15;
    expect_v(K_INST2, 8'hB3);
    tick();

    // Good load; checksum of this pattern is 0xD8.
    pat = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86, 8'h97, 8'hA8,
            8'hB9, 8'hCA, 8'hDB, 8'hEC, 8'hFD, 8'h0E, 8'h1F, 8'h00};
    expect_v(K_CLRACC, 8'h00);
    start_load();
    expect_state(ST_LOAD);
    expect_v(K_BUSY, 8'h01);
    expect_v(K_READY, 8'h01);
    expect_v(K_RSTN, 8'h00);
    send_pat();
    expect_state(ST_CSUM);
    expect_v(K_READY, 8'h01);
    expect_v(K_BUSY, 8'h01);
    expect_v(K_RSTN, 8'h00);
    send_byte(8'hD8);
    expect_v(K_RSTN, 8'h01);
    expect_state(ST_RUN);
    expect_v(K_BUSY, 8'h00);
    expect_v(K_READY, 8'h00);
    expect_v(K_ERR, 8'h00);
    expect_v(K_ACC, 8'd17);
    read_check(4'd0, 8'h31);
    read_check(4'd1, 8'h42);
    read_check(4'd13, 8'h0E);
    read_check(4'd15, 8'h00);

    // Bad checksum: sum+1, then a stray byte in ERR, then ld_start clears err.
    expect_v(K_CLRACC, 8'h00);
    start_load();
    send_pat();
    send_byte(8'hD9);
    expect_v(K_ERR, 8'h01);
    expect_v(K_RSTN, 8'h00);
    expect_v(K_READY, 8'h00);
    expect_state(ST_ERR);
    expect_v(K_ACC, 8'd17);
    send_ignored(8'h77);
    read_check(4'd1, 8'h42);
    expect_v(K_ERR, 8'h01);
    start_load();
    expect_v(K_ERR, 8'h00);
    expect_state(ST_LOAD);

    // Backpressure: one idle cycle after every byte; checksum of 0x11*i is 0xF8.
    pat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
            8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    expect_v(K_CLRACC, 8'h00);
    start_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(pat[i]);
      expect_v(K_BUSY, 8'h01);
      tick();
    end
    expect_v(K_BUSY, 8'h01);
    send_byte(8'hF8);
    expect_v(K_ACC, 8'd17);
    expect_state(ST_RUN);
    for (int i = 0; i < 16; i++) read_check(4'(i), pat[i]);

    // Restart after 7 bytes, with a byte offered alongside ld_start; checksum 0x78.
    start_load();
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    expect_state(ST_LOAD);
    pat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
            8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
    expect_v(K_CLRACC, 8'h00);
    send_pat();
    send_byte(8'h78);
    expect_v(K_RSTN, 8'h01);
    expect_state(ST_RUN);
    expect_v(K_ACC, 8'd17);
    read_check(4'd0, 8'hA0);
    read_check(4'd6, 8'hA6);
    read_check(4'd15, 8'hAF);

    // Reset in the middle of a load clears everything.
    start_load();
    for (int i = 1; i <= 5; i++) send_byte(8'h11 * 8'(i));
    reset_dut();
    expect_state(ST_IDLE);
    expect_v(K_RSTN, 8'h00);
    for (int i = 0; i < 16; i++) read_check(4'(i), 8'h00);

    tick();
    done = 1'b1;
    wait (report_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
